mii_tx_arb: RTL and testbench

//  Arbitrates the PCS transmit nibble stream between the external MII (via the
//  MII TX pad block) and an internal local nibble source (test/pattern/loopback).

---
 rtl/mii_tx_arb.sv | 144 ++++++++++++++
 tb/tb_mii_tx_arb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_tx_arb.sv
// PCS transmit nibble arbiter: picks the MII or a local nibble source per frame,
// enforces an inter-packet gap before local frames and sequences pad isolate.
module mii_tx_arb #(
   parameter int IPG_NIBBLES = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       isolate_req,
   output logic       isolate,
   input  logic       mii_ce,
   input  logic       mii_enable,
   input  logic       mii_err,
   input  logic [3:0] mii_data,
   input  logic       loc_valid,
   input  logic       loc_last,
   input  logic       loc_err,
   input  logic [3:0] loc_data,
   output logic       loc_ready,
   output logic       ce,
   output logic       enable,
   output logic       err,
   output logic [3:0] data,
   output logic [1:0] owner,
   output logic       mii_dropped,
   output logic       loc_underrun
);
   localparam int CW = $clog2(IPG_NIBBLES + 1);
   localparam logic [CW-1:0] IPG_CNT = CW'(IPG_NIBBLES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MII   = 2'd1,
      S_LOCAL = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] gap_cnt;
   logic [CW-1:0] gap_next;
   logic          mii_blk;
   logic          mii_prev;
   logic          mii_rise;
   logic          mii_start;
   logic          gap_done;
   logic          iso_load;

   assign owner     = state;
   assign mii_rise  = mii_enable & ~mii_prev;
   // A blocked MII burst stays blocked until TX_EN drops, so frames are never joined mid-way.
   assign mii_start = mii_enable & ~isolate & ~mii_blk;
   assign gap_done  = (gap_cnt == IPG_CNT);
   assign gap_next  = gap_done ? gap_cnt : gap_cnt + 1'b1;
   assign iso_load  = (state != S_MII) | ~mii_enable;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         gap_cnt      <= IPG_CNT;
         mii_blk      <= 1'b0;
         mii_prev     <= 1'b0;
         isolate      <= 1'b1;
         ce           <= 1'b0;
         enable       <= 1'b0;
         err          <= 1'b0;
         data         <= 4'h0;
         loc_ready    <= 1'b0;
         mii_dropped  <= 1'b0;
         loc_underrun <= 1'b0;
      end else begin
         ce           <= mii_ce;
         loc_ready    <= 1'b0;
         mii_dropped  <= 1'b0;
         loc_underrun <= 1'b0;
         if (mii_ce) begin
            mii_prev <= mii_enable;
            if (!mii_enable) begin
               mii_blk <= 1'b0;
            end else if (mii_rise && (state == S_LOCAL || isolate)) begin
               mii_blk     <= 1'b1;
               mii_dropped <= 1'b1;
            end
            if (iso_load) isolate <= isolate_req;

            case (state)
               S_MII: begin
                  enable <= mii_enable;
                  err    <= mii_err;
                  data   <= mii_data;
                  if (!mii_enable) begin
                     state   <= S_GAP;
                     gap_cnt <= '0;
                  end
               end
               S_LOCAL: begin
                  enable <= 1'b1;
                  if (loc_valid) begin
                     err       <= loc_err;
                     data      <= loc_data;
                     loc_ready <= 1'b1;
                     if (loc_last) begin
                        state   <= S_GAP;
                        gap_cnt <= '0;
                     end
                  end else begin
                     // Source starved mid-frame: poison the nibble so the frame is discarded downstream.
                     err          <= 1'b1;
                     data         <= 4'h0;
                     loc_underrun <= 1'b1;
                     state        <= S_GAP;
                     gap_cnt      <= '0;
                  end
               end
               default: begin
                  if (mii_start) begin
                     state  <= S_MII;
                     enable <= 1'b1;
                     err    <= mii_err;
                     data   <= mii_data;
                  end else if (state == S_IDLE && loc_valid && gap_done) begin
                     enable    <= 1'b1;
                     err       <= loc_err;
                     data      <= loc_data;
                     loc_ready <= 1'b1;
                     if (loc_last) begin
                        state   <= S_GAP;
                        gap_cnt <= '0;
                     end else begin
                        state <= S_LOCAL;
                     end
                  end else begin
                     enable <= 1'b0;
                     err    <= 1'b0;
                     data   <= 4'h0;
                     if (state == S_GAP) begin
                        gap_cnt <= gap_next;
                        if (gap_next == IPG_CNT) state <= S_IDLE;
                     end
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mii_tx_arb.sv
// Bench for mii_tx_arb: slot-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized MII/local traffic.
module tb_mii_tx_arb;
   localparam int IPG = 24;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       isolate_req = 1'b0;
   logic       mii_ce = 1'b0, mii_enable = 1'b0, mii_err = 1'b0;
   logic [3:0] mii_data = 4'h0;
   logic       loc_valid = 1'b0, loc_last = 1'b0, loc_err = 1'b0;
   logic [3:0] loc_data = 4'h0;
   logic       isolate, loc_ready, ce, enable, err, mii_dropped, loc_underrun;
   logic [3:0] data;
   logic [1:0] owner;

   int n_chk = 0, n_fail = 0;
   logic [5:0] mq[$];     // {en, err, data} per MII slot
   logic [5:0] lq[$];     // {err, last, data} per local nibble
   logic [4:0] cap_q[$];  // {err, data} of every enabled output nibble
   int zrun = 0, last_zrun = 0, n_lr = 0, n_drop = 0, n_und = 0;

   // reference model state
   int         m_owner, m_gap;
   bit         m_iso, m_ce, m_en, m_err, m_lr, m_drop, m_und, m_lock, m_prev_en;
   logic [3:0] m_data;

   always #5 clk = ~clk;

   mii_tx_arb #(.IPG_NIBBLES(IPG)) dut (
      .clk(clk), .rst(rst), .isolate_req(isolate_req), .isolate(isolate),
      .mii_ce(mii_ce), .mii_enable(mii_enable), .mii_err(mii_err), .mii_data(mii_data),
      .loc_valid(loc_valid), .loc_last(loc_last), .loc_err(loc_err), .loc_data(loc_data),
      .loc_ready(loc_ready), .ce(ce), .enable(enable), .err(err), .data(data),
      .owner(owner), .mii_dropped(mii_dropped), .loc_underrun(loc_underrun)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic end_frame();
      m_owner = 3;
      m_gap   = 0;
   endtask

   // One nibble slot of the arbitration rules, in terms of frames and elapsed idle slots.
   task automatic model_slot();
      bit rise, can_mii, in_mii;
      rise    = mii_enable && !m_prev_en;
      can_mii = mii_enable && !m_iso && !m_lock;
      in_mii  = (m_owner == 1);
      if (!mii_enable) m_lock = 0;
      else if (rise && (m_owner == 2 || m_iso)) begin
         m_lock = 1;
         m_drop = 1;
      end
      if (!in_mii || !mii_enable) m_iso = isolate_req;
      m_prev_en = mii_enable;
      case (m_owner)
         1: begin
            m_en = mii_enable; m_err = mii_err; m_data = mii_data;
            if (!mii_enable) end_frame();
         end
         2: begin
            m_en = 1;
            if (loc_valid) begin
               m_err = loc_err; m_data = loc_data; m_lr = 1;
               if (loc_last) end_frame();
            end else begin
               m_err = 1; m_data = 4'h0; m_und = 1;
               end_frame();
            end
         end
         default: begin
            if (can_mii) begin
               m_owner = 1; m_en = 1; m_err = mii_err; m_data = mii_data;
            end else if (m_owner == 0 && loc_valid && m_gap >= IPG) begin
               m_en = 1; m_err = loc_err; m_data = loc_data; m_lr = 1;
               if (loc_last) end_frame(); else m_owner = 2;
            end else begin
               m_en = 0; m_err = 0; m_data = 4'h0;
               if (m_owner == 3) begin
                  m_gap++;
                  if (m_gap >= IPG) m_owner = 0;
               end
            end
         end
      endcase
   endtask

   // Model update at each edge, DUT compare 1 time unit later, plus capture for directed checks.
   always @(posedge clk) begin
      if (rst) begin
         m_owner = 0; m_gap = IPG; m_iso = 1; m_ce = 0; m_en = 0; m_err = 0; m_data = 4'h0;
         m_lr = 0; m_drop = 0; m_und = 0; m_lock = 0; m_prev_en = 0;
      end else begin
         m_ce = mii_ce; m_lr = 0; m_drop = 0; m_und = 0;
         if (mii_ce) model_slot();
      end
      #1;
      chk("ce", ce, m_ce);
      chk("loc_ready", loc_ready, m_lr);
      chk("mii_dropped", mii_dropped, m_drop);
      chk("loc_underrun", loc_underrun, m_und);
      chk("owner", owner, m_owner);
      chk("isolate", isolate, m_iso);
      chk("enable", enable, m_en);
      if (m_en) begin
         chk("err", err, m_err);
         chk("data", data, m_data);
      end
      if (ce) begin
         if (enable) begin
            cap_q.push_back({err, data});
            if (zrun > 0) last_zrun = zrun;
            zrun = 0;
         end else zrun++;
      end
      if (loc_ready) n_lr++;
      if (mii_dropped) n_drop++;
      if (loc_underrun) n_und++;
   end

   // Called at a negedge; presents both sources, strobes one slot, then 4 quiet cycles.
   task automatic slot();
      if (mq.size() > 0) {mii_enable, mii_err, mii_data} = mq.pop_front();
      else begin
         mii_enable = 1'b0; mii_err = 1'($urandom); mii_data = 4'($urandom);
      end
      if (lq.size() > 0) begin
         loc_valid = 1'b1;
         {loc_err, loc_last, loc_data} = lq[0];
      end else begin
         loc_valid = 1'b0; loc_last = 1'($urandom); loc_err = 1'($urandom); loc_data = 4'($urandom);
      end
      mii_ce = 1'b1;
      @(negedge clk);
      mii_ce = 1'b0;
      if (loc_ready && lq.size() > 0) lq.delete(0);
      repeat (4) @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) slot();
   endtask

   task automatic push_mii_rand(input int n);
      for (int i = 0; i < n; i++)
         mq.push_back({1'b1, 1'($urandom_range(0, 15) == 0), 4'($urandom)});
   endtask

   task automatic push_loc_rand(input int n, input bit with_last);
      for (int i = 0; i < n; i++)
         lq.push_back({1'($urandom_range(0, 15) == 0), 1'(with_last && i == n - 1), 4'($urandom)});
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_isolate", isolate, 1);
      chk("rst_owner", owner, 0);
      chk("rst_enable", enable, 0);
      chk("rst_data", data, 0);
      chk("rst_loc_ready", loc_ready, 0);
      rst = 1'b0;
      @(negedge clk);

      // MII preamble frame: isolate released on the first slot, 16 nibbles forwarded
      run(1);
      chk("iso_first_slot", isolate, 0);
      run(1);
      cap_q.delete();
      for (int i = 0; i < 16; i++) mq.push_back({2'b10, (i < 15) ? 4'h5 : 4'hD});
      run(3);
      chk("mii_owner", owner, 1);
      run(15);
      chk("mii_owner_gap", owner, 3);
      chk("mii_nibbles", cap_q.size(), 16);
      if (cap_q.size() >= 16)
         for (int i = 0; i < 16; i++) chk("mii_frame_data", cap_q[i], (i < 15) ? 5'h05 : 5'h0D);

      // Two back-to-back local frames: 8 then 4 nibbles, 24 idle slots between
      cap_q.delete(); n_lr = 0; last_zrun = 0;
      for (int i = 0; i < 8; i++) lq.push_back({1'b0, 1'(i == 7), 4'(i + 1)});
      for (int i = 0; i < 4; i++) lq.push_back({1'b0, 1'(i == 3), 4'(i + 9)});
      run(70);
      chk("loc_ready_count", n_lr, 12);
      chk("loc_gap_slots", last_zrun, 24);
      chk("loc_nibbles", cap_q.size(), 12);
      if (cap_q.size() >= 8)
         for (int i = 0; i < 8; i++) chk("loc_frame_data", cap_q[i], 5'(i + 1));

      // Tie: MII and local both present on the same slot
      run(30);
      n_lr = 0;
      for (int i = 0; i < 6; i++) mq.push_back({2'b10, 4'(i + 3)});
      for (int i = 0; i < 3; i++) lq.push_back({1'b0, 1'(i == 2), 4'hA});
      run(3);
      chk("tie_owner", owner, 1);
      run(28);
      chk("tie_loc_held", n_lr, 0);
      run(1);
      chk("tie_loc_first", n_lr, 1);
      run(10);

      // MII rises three nibbles into a local frame
      run(30);
      cap_q.delete(); n_drop = 0;
      for (int i = 0; i < 8; i++) lq.push_back({1'b0, 1'(i == 7), 4'(i + 8)});
      run(3);
      push_mii_rand(5);
      run(25);
      chk("drop_count", n_drop, 1);
      chk("drop_loc_nibbles", cap_q.size(), 8);
      if (cap_q.size() >= 8)
         for (int i = 0; i < 8; i++) chk("drop_loc_data", cap_q[i], 5'(i + 8));

      // Local source starves at nibble 5
      run(30);
      cap_q.delete(); n_und = 0;
      for (int i = 0; i < 4; i++) lq.push_back({2'b00, 4'(i + 12)});
      run(5);
      chk("und_nibbles", cap_q.size(), 5);
      if (cap_q.size() >= 5) chk("und_poison", cap_q[4], 5'h10);
      chk("und_count", n_und, 1);
      chk("und_owner", owner, 3);

      // isolate request inside an MII frame waits for the frame end
      run(30);
      for (int i = 0; i < 10; i++) mq.push_back({2'b10, 4'(i)});
      run(3);
      isolate_req = 1'b1;
      run(7);
      chk("iso_held", isolate, 0);
      run(1);
      chk("iso_at_end", isolate, 1);
      isolate_req = 1'b0;
      run(1);
      chk("iso_release", isolate, 0);

      // Async reset in the middle of a local frame
      run(30);
      for (int i = 0; i < 8; i++) lq.push_back({1'b0, 1'(i == 7), 4'(i)});
      run(3);
      chk("pre_rst_enable", enable, 1);
      chk("pre_rst_owner", owner, 2);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_enable", enable, 0);
      chk("async_rst_isolate", isolate, 1);
      chk("async_rst_owner", owner, 0);
      @(negedge clk);
      lq.delete(); mq.delete(); loc_valid = 1'b0; mii_enable = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if (mq.size() == 0 && $urandom_range(0, 9) == 0) begin
            push_mii_rand($urandom_range(2, 20));
            repeat ($urandom_range(1, 3)) mq.push_back({2'b00, 4'($urandom)});
         end
         if (lq.size() == 0 && $urandom_range(0, 5) == 0)
            push_loc_rand($urandom_range(2, 12), $urandom_range(0, 7) != 0);
         if ($urandom_range(0, 99) == 0) isolate_req = ~isolate_req;
         slot();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
